// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one RV32 data-memory port between
// the pipeline (requester 0) and a DMA/loader (requester 1); faulting accesses never write.
module dmem_arbiter #(
    parameter int WIDTH_ADDR = 15,
    parameter int Data_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_0,
    output logic                  req_ready_0,
    input  logic                  req_we_0,
    input  logic [Data_WIDTH-1:0] req_addr_0,
    input  logic [Data_WIDTH-1:0] req_wdata_0,
    input  logic [2:0]            req_size_0,
    output logic                  resp_valid_0,
    input  logic                  resp_ready_0,
    output logic [Data_WIDTH-1:0] resp_rdata_0,
    output logic                  resp_err_0,
    input  logic                  req_valid_1,
    output logic                  req_ready_1,
    input  logic                  req_we_1,
    input  logic [Data_WIDTH-1:0] req_addr_1,
    input  logic [Data_WIDTH-1:0] req_wdata_1,
    input  logic [2:0]            req_size_1,
    output logic                  resp_valid_1,
    input  logic                  resp_ready_1,
    output logic [Data_WIDTH-1:0] resp_rdata_1,
    output logic                  resp_err_1,
    output logic                  mem_we,
    output logic [Data_WIDTH-1:0] mem_addr,
    output logic [Data_WIDTH-1:0] mem_wdata,
    output logic [2:0]            mem_size,
    input  logic [Data_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_grant;
    logic                  r_gnt;
    logic                  r_we;
    logic [Data_WIDTH-1:0] r_addr;
    logic [Data_WIDTH-1:0] r_wdata;
    logic [2:0]            r_size;
    logic [Data_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_gnt;
    logic                  w_hs;
    logic                  w_err;
    logic                  w_resp_ready;
    logic                  w_sel_we;
    logic [Data_WIDTH-1:0] w_sel_addr;
    logic [Data_WIDTH-1:0] w_sel_wdata;
    logic [2:0]            w_sel_size;

    // A tie goes to whoever was not served last; ready is masked while reset is held.
    always_comb begin
        if (req_valid_0 && !req_valid_1) begin
            w_gnt = 1'b0;
        end else if (!req_valid_0 && req_valid_1) begin
            w_gnt = 1'b1;
        end else begin
            w_gnt = ~r_last_grant;
        end
        w_hs        = rst_n && (r_state == IDLE) && (req_valid_0 || req_valid_1);
        req_ready_0 = w_hs && !w_gnt;
        req_ready_1 = w_hs && w_gnt;
        w_sel_we    = w_gnt ? req_we_1    : req_we_0;
        w_sel_addr  = w_gnt ? req_addr_1  : req_addr_0;
        w_sel_wdata = w_gnt ? req_wdata_1 : req_wdata_0;
        w_sel_size  = w_gnt ? req_size_1  : req_size_0;
    end

    always_comb begin
        w_err = 1'b0;
        case (r_size[1:0])
            2'b00:   w_err = (r_addr[1:0] != 2'b00);
            2'b10:   w_err = r_addr[0];
            2'b11:   w_err = 1'b1;
            default: w_err = 1'b0;
        endcase
        if (|r_addr[Data_WIDTH-1:WIDTH_ADDR+2]) begin
            w_err = 1'b1;
        end
    end

    assign w_resp_ready = r_gnt ? resp_ready_1 : resp_ready_0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_nxt = ACCESS;
            ACCESS:  w_state_nxt = RESP;
            RESP:    if (w_resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_size       <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_gnt        <= w_gnt;
                r_last_grant <= w_gnt;
                r_we         <= w_sel_we;
                r_addr       <= w_sel_addr;
                r_wdata      <= w_sel_wdata;
                r_size       <= w_sel_size;
            end
            if (r_state == ACCESS) begin
                r_rdata <= (!r_we && !w_err) ? mem_rdata : '0;
                r_err   <= w_err;
            end
        end
    end

    // Memory-side fields stay at their latched values outside ACCESS to avoid toggling.
    assign mem_we    = (r_state == ACCESS) && r_we && !w_err;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_size  = r_size;

    assign resp_valid_0 = (r_state == RESP) && !r_gnt;
    assign resp_valid_1 = (r_state == RESP) && r_gnt;
    assign resp_rdata_0 = resp_valid_0 ? r_rdata : '0;
    assign resp_rdata_1 = resp_valid_1 ? r_rdata : '0;
    assign resp_err_0   = resp_valid_0 && r_err;
    assign resp_err_1   = resp_valid_1 && r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a cycle-count
// reference model, with a scoreboard monitor checking responses and memory writes.
module tb_dmem_arbiter;

    localparam int          WA        = 15;
    localparam logic [31:0] MEM_BYTES = 32'(4 * (2 ** WA));

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  v, we, rr;
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [2:0]  size [2];
    logic        rdy0, rdy1, rv0, rv1, re0, re1;
    logic [31:0] rd0, rd1;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [2:0]  mem_size;

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return ((a - 32'h10) * 32'h9E3779B1) ^ 32'hDEADBEEF;
    endfunction

    assign mem_rdata = memfn(mem_addr);

    dmem_arbiter #(.WIDTH_ADDR(WA), .Data_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(v[0]), .req_ready_0(rdy0), .req_we_0(we[0]), .req_addr_0(addr[0]),
        .req_wdata_0(wdata[0]), .req_size_0(size[0]), .resp_valid_0(rv0),
        .resp_ready_0(rr[0]), .resp_rdata_0(rd0), .resp_err_0(re0),
        .req_valid_1(v[1]), .req_ready_1(rdy1), .req_we_1(we[1]), .req_addr_1(addr[1]),
        .req_wdata_1(wdata[1]), .req_size_1(size[1]), .resp_valid_1(rv1),
        .resp_ready_1(rr[1]), .resp_rdata_1(rd1), .resp_err_1(re1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_size(mem_size), .mem_rdata(mem_rdata)
    );

    typedef struct packed {logic [31:0] rdata; logic err;} resp_t;
    typedef struct packed {logic [31:0] a; logic [31:0] d; logic [2:0] s;} wr_t;

    resp_t rq0[$], rq1[$];
    wr_t   wq[$];
    int    hs_cyc[$];
    bit    hs_id[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit keep = 1'b0;

    // reference model state: busy with requester m_g, m_age cycles after its accept
    bit m_busy, m_last, m_g, m_store_ok;
    int m_age;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail(string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endfunction

    function automatic bit fault(logic [31:0] a, logic [2:0] s);
        return (s[1:0] == 2'b11) || (s[1:0] == 2'b00 && (a % 4) != 0) ||
               (s[1:0] == 2'b10 && (a % 2) != 0) || (a >= MEM_BYTES);
    endfunction

    // One clock: check handshake/response/write timing at negedge, update model, drive after posedge.
    task automatic tick();
        bit eg, er0, er1, k, e;
        bit [1:0] hs;
        @(negedge clk);
        cyc++;
        hs  = 2'b00;
        eg  = (v[0] && v[1]) ? !m_last : v[1];
        er0 = !m_busy && v[0] && !eg;
        er1 = !m_busy && v[1] && eg;
        chk("req_ready_0", 32'(rdy0), 32'(er0));
        chk("req_ready_1", 32'(rdy1), 32'(er1));
        chk("resp_valid_0", 32'(rv0), 32'(m_busy && m_age >= 2 && !m_g));
        chk("resp_valid_1", 32'(rv1), 32'(m_busy && m_age >= 2 && m_g));
        chk("mem_we", 32'(mem_we), 32'(m_busy && m_age == 1 && m_store_ok));
        if (m_busy) begin
            if (m_age >= 2 && rr[m_g]) m_busy = 1'b0;
            else m_age++;
        end else if (er0 || er1) begin
            k = er1;
            e = fault(addr[k], size[k]);
            if (k) rq1.push_back('{rdata: (!we[k] && !e) ? memfn(addr[k]) : 32'h0, err: e});
            else   rq0.push_back('{rdata: (!we[k] && !e) ? memfn(addr[k]) : 32'h0, err: e});
            m_store_ok = we[k] && !e;
            if (m_store_ok) wq.push_back('{a: addr[k], d: wdata[k], s: size[k]});
            m_busy = 1'b1;
            m_age  = 1;
            m_last = k;
            m_g    = k;
            hs[k]  = 1'b1;
            hs_cyc.push_back(cyc);
            hs_id.push_back(k);
        end
        @(posedge clk);
        #1;
        if (!keep) v = v & ~hs;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        v     = 2'b11;
        #1;
        rq0.delete();
        rq1.delete();
        wq.delete();
        m_busy = 1'b0;
        m_last = 1'b1;
        m_age  = 0;
        chk("rst_req_ready_0", 32'(rdy0), 0);
        chk("rst_req_ready_1", 32'(rdy1), 0);
        chk("rst_resp_valid", 32'({rv0, rv1}), 0);
        chk("rst_resp_rdata", rd0 | rd1, 0);
        chk("rst_resp_err", 32'({re0, re1}), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_size", 32'(mem_size), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        v = 2'b00;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (m_busy && t < 50) begin
            tick();
            t++;
        end
        if (m_busy) fail("wait_idle timeout");
    endtask

    task automatic do_req(bit k, bit w, logic [31:0] a, logic [31:0] d, logic [2:0] s);
        int base = hs_cyc.size();
        int t = 0;
        we[k] = w; addr[k] = a; wdata[k] = d; size[k] = s; v[k] = 1'b1;
        while (hs_cyc.size() == base && t < 20) begin
            tick();
            t++;
        end
        if (hs_cyc.size() == base) fail("do_req accept timeout");
        else chk("do_req_grant_id", 32'(hs_id[base]), 32'(k));
        wait_idle();
    endtask

    // Scoreboard monitor: compares every presented response and every memory write.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rv0) begin
                if (rq0.size() == 0) fail("resp_0 unexpected");
                else begin
                    chk("resp_rdata_0", rd0, rq0[0].rdata);
                    chk("resp_err_0", 32'(re0), 32'(rq0[0].err));
                    if (rr[0]) void'(rq0.pop_front());
                end
            end else begin
                chk("idle_rdata_0", rd0, 0);
                chk("idle_err_0", 32'(re0), 0);
            end
            if (rv1) begin
                if (rq1.size() == 0) fail("resp_1 unexpected");
                else begin
                    chk("resp_rdata_1", rd1, rq1[0].rdata);
                    chk("resp_err_1", 32'(re1), 32'(rq1[0].err));
                    if (rr[1]) void'(rq1.pop_front());
                end
            end else begin
                chk("idle_rdata_1", rd1, 0);
                chk("idle_err_1", 32'(re1), 0);
            end
            if (mem_we) begin
                if (wq.size() == 0) fail("mem_we unexpected");
                else begin
                    chk("wr_addr", mem_addr, wq[0].a);
                    chk("wr_wdata", mem_wdata, wq[0].d);
                    chk("wr_size", 32'(mem_size), 32'(wq[0].s));
                    void'(wq.pop_front());
                end
            end
        end
    end

    initial begin
        int base;
        rst_n = 1'b0;
        v = 2'b00; we = 2'b00; rr = 2'b11;
        for (int i = 0; i < 2; i++) begin
            addr[i] = '0; wdata[i] = '0; size[i] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();

        do_req(1'b0, 1'b0, 32'h10, 32'h0, 3'b000);
        do_req(1'b1, 1'b1, 32'h20, 32'h12345678, 3'b000);
        do_req(1'b0, 1'b1, 32'h22, 32'hA5A5A5A5, 3'b000);
        do_req(1'b1, 1'b0, 32'h21, 32'h0, 3'b010);
        do_req(1'b0, 1'b0, 32'h30, 32'h0, 3'b011);
        do_req(1'b1, 1'b0, 32'h0002_0000, 32'h0, 3'b000);
        do_req(1'b0, 1'b1, 32'h0002_0000, 32'h55AA55AA, 3'b000);
        do_req(1'b1, 1'b1, 32'h33, 32'h000000AB, 3'b001);
        do_req(1'b0, 1'b0, 32'h0001_FFFE, 32'h0, 3'b110);

        // contention straight after reset: 0 first, then alternating every 3 cycles
        do_reset();
        keep = 1'b1;
        we = 2'b00; addr[0] = 32'h100; addr[1] = 32'h204; size[0] = 3'b000; size[1] = 3'b000;
        v = 2'b11;
        base = hs_cyc.size();
        repeat (12) tick();
        keep = 1'b0;
        v = 2'b00;
        chk("contention_grants", 32'(hs_cyc.size() - base), 4);
        for (int i = 0; i < 4 && base + i < hs_cyc.size(); i++) begin
            chk("contention_id", 32'(hs_id[base + i]), 32'(i % 2));
            if (i > 0) chk("contention_spacing", 32'(hs_cyc[base + i] - hs_cyc[base + i - 1]), 3);
        end
        wait_idle();

        // back-pressure on requester 0 while requester 1 waits
        we = 2'b00; addr[0] = 32'h300; addr[1] = 32'h304; size[0] = 3'b000; size[1] = 3'b000;
        rr = 2'b10;
        v = 2'b11;
        base = hs_cyc.size();
        repeat (7) tick();
        chk("bp_single_grant", 32'(hs_cyc.size() - base), 1);
        rr = 2'b11;
        tick();
        tick();
        chk("bp_second_grant", 32'(hs_cyc.size() - base), 2);
        if (hs_cyc.size() - base == 2) begin
            chk("bp_second_id", 32'(hs_id[base + 1]), 1);
            chk("bp_second_cycle", 32'(hs_cyc[base + 1] - hs_cyc[base]), 8);
        end
        wait_idle();

        // reset while a store is in ACCESS
        we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'hCAFEF00D; size[0] = 3'b000;
        v = 2'b01;
        base = hs_cyc.size();
        tick();
        chk("rst_test_accept", 32'(hs_cyc.size() - base), 1);
        chk("rst_test_mem_we_high", 32'(mem_we), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_test_mem_we_async", 32'(mem_we), 0);
        do_reset();
        do_req(1'b0, 1'b0, 32'h40, 32'h0, 3'b000);

        // randomized mixed traffic with random back-pressure and request withdrawal
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!v[k]) begin
                    if ($urandom_range(1, 0) == 1) begin
                        we[k]    = 1'($urandom_range(1, 0));
                        size[k]  = 3'($urandom_range(7, 0));
                        wdata[k] = $urandom;
                        case ($urandom_range(7, 0))
                            0:       addr[k] = $urandom;
                            1:       addr[k] = MEM_BYTES - 32'd4;
                            2:       addr[k] = MEM_BYTES;
                            default: addr[k] = 32'($urandom_range(int'(MEM_BYTES) - 1, 0));
                        endcase
                        v[k] = 1'b1;
                    end
                end else if ($urandom_range(7, 0) == 0) begin
                    v[k] = 1'b0;
                end
                rr[k] = ($urandom_range(3, 0) != 0);
            end
            tick();
        end
        v = 2'b00;
        rr = 2'b11;
        tick();
        wait_idle();
        tick();
        chk("final_rq0_empty", 32'(rq0.size()), 0);
        chk("final_rq1_empty", 32'(rq1.size()), 0);
        chk("final_wq_empty", 32'(wq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
